// File: rtl/statki_pkg.sv
// ---------------------------------------------------------------------------
// statki_pkg
// Shared definitions for the battleship ("statki") game datapath:
//   - program-state codes exchanged between the game FSM, the turn
//     scheduler and find_ships
//   - board geometry (bitmap width, on-screen origin and square size)
//   - the turn scheduler's internal state enumeration
// Boards are 8x8 bitmaps, row-major, index = x + 8*y.
// ---------------------------------------------------------------------------
package statki_pkg;

  localparam int BOARD_BITS     = 64;
  localparam int BOARD_DIM      = 8;
  localparam int BOARD_ORIGIN_X = 64;
  localparam int BOARD_ORIGIN_Y = 112;
  localparam int SQUARE_SIZE    = 40;

  typedef enum logic [3:0] {
    PS_IDLE            = 4'b0000,
    PS_FINDING_SHIPS   = 4'b0100,
    PS_SCREEN_BLANKING = 4'b0101,
    PS_GAME_ENDING     = 4'b0110
  } program_state_t;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_FINDING,
    SCHED_SCAN,
    SCHED_DECIDE,
    SCHED_BLANK,
    SCHED_ENDING
  } sched_state_t;

  // SCAN and DECIDE report blanking so find_ships ignores clicks while the
  // boards are being scanned.
  function automatic program_state_t program_code(input sched_state_t s);
    case (s)
      SCHED_FINDING: return PS_FINDING_SHIPS;
      SCHED_SCAN:    return PS_SCREEN_BLANKING;
      SCHED_DECIDE:  return PS_SCREEN_BLANKING;
      SCHED_BLANK:   return PS_SCREEN_BLANKING;
      SCHED_ENDING:  return PS_GAME_ENDING;
      default:       return PS_IDLE;
    endcase
  endfunction

  // Pixel position of the top-left corner of a board square.
  function automatic int square_origin_x(input int col);
    return BOARD_ORIGIN_X + col * SQUARE_SIZE;
  endfunction

  function automatic int square_origin_y(input int row);
    return BOARD_ORIGIN_Y + row * SQUARE_SIZE;
  endfunction

  function automatic int cell_index(input int col, input int row);
    return col + BOARD_DIM * row;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// ---------------------------------------------------------------------------
// turn_scheduler_if
// Bundles the turn scheduler's control pulses, board bitmaps and status
// outputs.
//   master : game side; drives start/restart/mouse_right_tick/finished_move
//            and the four board bitmaps, observes the status outputs
//   slave  : the turn scheduler itself
// Status: game_state[3:0], game_active, active_player, hits_p1[6:0],
//         hits_p2[6:0], game_over, winner
// ---------------------------------------------------------------------------
interface turn_scheduler_if;
  import statki_pkg::*;

  logic                  start;
  logic                  restart;
  logic                  mouse_right_tick;
  logic                  finished_move;
  logic [BOARD_BITS-1:0] player1_board;
  logic [BOARD_BITS-1:0] player2_board;
  logic [BOARD_BITS-1:0] player1_ships;
  logic [BOARD_BITS-1:0] player2_ships;

  logic [3:0]            game_state;
  logic                  game_active;
  logic                  active_player;
  logic [6:0]            hits_p1;
  logic [6:0]            hits_p2;
  logic                  game_over;
  logic                  winner;

  modport master (
    output start, restart, mouse_right_tick, finished_move,
           player1_board, player2_board, player1_ships, player2_ships,
    input  game_state, game_active, active_player, hits_p1, hits_p2,
           game_over, winner
  );

  modport slave (
    input  start, restart, mouse_right_tick, finished_move,
           player1_board, player2_board, player1_ships, player2_ships,
    output game_state, game_active, active_player, hits_p1, hits_p2,
           game_over, winner
  );

endinterface

// File: rtl/turn_scheduler_hit_scanner.sv
// ---------------------------------------------------------------------------
// hit_scanner
// Serially walks a shot map and a ship map one bit per cycle (idx 0..63),
// counting hits (shot & ship) and fleet squares (ship).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              pulse; clears idx and both accumulators, begins scan
//   shot_map, ship_map 64-bit bitmaps, sampled live during the scan
//   done               high in the cycle the final bit (idx 63) is added,
//                      so the accumulators are final on the following cycle
//   hit_acc, ship_acc  running counts (max 64, never overflow 7 bits)
// ---------------------------------------------------------------------------
module hit_scanner
  import statki_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BOARD_BITS-1:0] shot_map,
  input  logic [BOARD_BITS-1:0] ship_map,
  output logic                  done,
  output logic [6:0]            hit_acc,
  output logic [6:0]            ship_acc
);

  logic [5:0] idx;
  logic       busy;

  // done is combinational so the scheduler can leave SCAN on the same edge
  // that adds the last bit, giving exactly 64 scan cycles.
  assign done = busy && (idx == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 6'd0;
      busy     <= 1'b0;
      hit_acc  <= 7'd0;
      ship_acc <= 7'd0;
    end else if (start) begin
      idx      <= 6'd0;
      busy     <= 1'b1;
      hit_acc  <= 7'd0;
      ship_acc <= 7'd0;
    end else if (busy) begin
      hit_acc  <= hit_acc + {6'd0, shot_map[idx] & ship_map[idx]};
      ship_acc <= ship_acc + {6'd0, ship_map[idx]};
      idx      <= idx + 6'd1;
      if (idx == 6'd63) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// ---------------------------------------------------------------------------
// turn_scheduler
// Runs the shooting phase: alternates turns between the two players with a
// screen-blanking interlude, scans the shooter's shot map against the
// opponent's fleet after every committed move and detects the winner.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        turn_scheduler_if.slave (pulses, boards, status outputs)
// Parameters:
//   BLANK_CYCLES  minimum cycles in blanking before a right click counts
//   BLANK_W       blanking counter width, 2**BLANK_W > BLANK_CYCLES
// All status outputs are registered.
// ---------------------------------------------------------------------------
module turn_scheduler
  import statki_pkg::*;
#(
  parameter int BLANK_CYCLES = 6500000,
  parameter int BLANK_W      = 23
) (
  input  logic             clk,
  input  logic             rst,
  turn_scheduler_if.slave  bus
);

  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES - 1);

  sched_state_t          state, state_next;
  logic                  active_player, player_next;
  logic [6:0]            hits_p1, hits_p1_next;
  logic [6:0]            hits_p2, hits_p2_next;
  logic                  game_over, over_next;
  logic                  winner, winner_next;
  logic [BLANK_W-1:0]    blank_cnt, blank_next;
  logic [3:0]            game_state_q;
  logic                  game_active_q;

  logic                  scan_start;
  logic                  scan_done;
  logic [6:0]            hit_acc;
  logic [6:0]            ship_acc;
  logic [BOARD_BITS-1:0] shot_map;
  logic [BOARD_BITS-1:0] ship_map;

  // The shooter's own shots are checked against the opponent's fleet.
  assign shot_map = active_player ? bus.player2_board : bus.player1_board;
  assign ship_map = active_player ? bus.player1_ships : bus.player2_ships;

  hit_scanner u_scanner (
    .clk      (clk),
    .rst      (rst),
    .start    (scan_start),
    .shot_map (shot_map),
    .ship_map (ship_map),
    .done     (scan_done),
    .hit_acc  (hit_acc),
    .ship_acc (ship_acc)
  );

  // State and registered outputs; game_state/game_active are decoded from
  // the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SCHED_IDLE;
      active_player <= 1'b0;
      hits_p1       <= 7'd0;
      hits_p2       <= 7'd0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      blank_cnt     <= '0;
      game_state_q  <= PS_IDLE;
      game_active_q <= 1'b0;
    end else begin
      state         <= state_next;
      active_player <= player_next;
      hits_p1       <= hits_p1_next;
      hits_p2       <= hits_p2_next;
      game_over     <= over_next;
      winner        <= winner_next;
      blank_cnt     <= blank_next;
      game_state_q  <= program_code(state_next);
      game_active_q <= (state_next != SCHED_IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next   = state;
    player_next  = active_player;
    hits_p1_next = hits_p1;
    hits_p2_next = hits_p2;
    over_next    = game_over;
    winner_next  = winner;
    blank_next   = blank_cnt;
    scan_start   = 1'b0;

    case (state)
      SCHED_IDLE: begin
        if (bus.start) begin
          state_next   = SCHED_FINDING;
          player_next  = 1'b0;
          hits_p1_next = 7'd0;
          hits_p2_next = 7'd0;
        end
      end
      SCHED_FINDING: begin
        if (bus.finished_move) begin
          state_next = SCHED_SCAN;
          scan_start = 1'b1;
        end
      end
      SCHED_SCAN: begin
        if (scan_done) begin
          state_next = SCHED_DECIDE;
        end
      end
      SCHED_DECIDE: begin
        if (active_player) begin
          hits_p2_next = hit_acc;
        end else begin
          hits_p1_next = hit_acc;
        end
        // An empty fleet never counts as sunk.
        if ((ship_acc != 7'd0) && (hit_acc == ship_acc)) begin
          state_next  = SCHED_ENDING;
          winner_next = active_player;
          over_next   = 1'b1;
        end else begin
          state_next  = SCHED_BLANK;
          player_next = ~active_player;
          blank_next  = '0;
        end
      end
      SCHED_BLANK: begin
        if (blank_cnt != BLANK_MAX) begin
          blank_next = blank_cnt + BLANK_W'(1);
        end
        // Early clicks are simply dropped, never remembered.
        if (bus.mouse_right_tick && (blank_cnt == BLANK_MAX)) begin
          state_next = SCHED_FINDING;
        end
      end
      SCHED_ENDING: begin
        if (bus.restart) begin
          state_next   = SCHED_IDLE;
          player_next  = 1'b0;
          hits_p1_next = 7'd0;
          hits_p2_next = 7'd0;
          over_next    = 1'b0;
          winner_next  = 1'b0;
          blank_next   = '0;
        end
      end
      default: begin
        state_next = SCHED_IDLE;
      end
    endcase
  end

  assign bus.game_state    = game_state_q;
  assign bus.game_active   = game_active_q;
  assign bus.active_player = active_player;
  assign bus.hits_p1       = hits_p1;
  assign bus.hits_p2       = hits_p2;
  assign bus.game_over     = game_over;
  assign bus.winner        = winner;

endmodule

// File: tb/tb_turn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_turn_scheduler
// Self-checking bench for turn_scheduler with a short blanking period
// (BLANK_CYCLES=10). Every committed move pushes the predicted result onto a
// queue; the entry is popped and compared when the DUT leaves DECIDE.
// ---------------------------------------------------------------------------
module tb_turn_scheduler;
  import statki_pkg::*;

  typedef struct {
    logic       player;
    logic [6:0] hits;
    logic       win;
  } move_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic exp_player;
  move_exp_t exp_q[$];

  turn_scheduler_if bus ();

  turn_scheduler #(
    .BLANK_CYCLES (10),
    .BLANK_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1; cycle(1); bus.start = 1'b0;
  endtask

  task automatic pulse_restart;
    bus.restart = 1'b1; cycle(1); bus.restart = 1'b0;
  endtask

  task automatic pulse_tick;
    bus.mouse_right_tick = 1'b1; cycle(1); bus.mouse_right_tick = 1'b0;
  endtask

  // Reference result of one move, computed from whole-board population counts.
  function automatic move_exp_t predict(input logic player);
    move_exp_t e;
    logic [63:0] shots, ships;
    shots = player ? bus.player2_board : bus.player1_board;
    ships = player ? bus.player1_ships : bus.player2_ships;
    e.player = player;
    e.hits   = 7'($countones(shots & ships));
    e.win    = ($countones(ships) != 0) && ($countones(shots & ships) == $countones(ships));
    return e;
  endfunction

  // Record the prediction, then commit the move (one edge).
  task automatic issue_move;
    exp_q.push_back(predict(exp_player));
    bus.finished_move = 1'b1; cycle(1); bus.finished_move = 1'b0;
  endtask

  // Right after BLANK entry: wait out the blanking period and click.
  task automatic skip_blank;
    cycle(9);
    pulse_tick;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.restart = 0; bus.mouse_right_tick = 0; bus.finished_move = 0;
    bus.player1_board = '0; bus.player2_board = '0;
    bus.player1_ships = '0; bus.player2_ships = '0;
    rst = 1'b1; cycle(2); rst = 1'b0;
    exp_player = 1'b0;
    checks++; if (bus.game_state !== 4'b0000) begin errors++; $display("[TB] FAIL reset_state: got %b expected 0000", bus.game_state); end
    checks++; if (bus.game_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", bus.game_active); end
    checks++; if (bus.active_player !== 1'b0) begin errors++; $display("[TB] FAIL reset_player: got %b expected 0", bus.active_player); end
    checks++; if ({bus.hits_p1, bus.hits_p2} !== 14'd0) begin errors++; $display("[TB] FAIL reset_hits: got %0d/%0d expected 0/0", bus.hits_p1, bus.hits_p2); end
    checks++; if ({bus.game_over, bus.winner} !== 2'b00) begin errors++; $display("[TB] FAIL reset_over: got %b%b expected 00", bus.game_over, bus.winner); end
  endtask

  task automatic test_start;
    pulse_start;
    exp_player = 1'b0;
    checks++; if (bus.game_state !== 4'b0100) begin errors++; $display("[TB] FAIL start_state: got %b expected 0100", bus.game_state); end
    checks++; if (bus.game_active !== 1'b1) begin errors++; $display("[TB] FAIL start_active: got %b expected 1", bus.game_active); end
    checks++; if (bus.active_player !== 1'b0) begin errors++; $display("[TB] FAIL start_player: got %b expected 0", bus.active_player); end
    pulse_start;
    checks++; if (bus.game_state !== 4'b0100) begin errors++; $display("[TB] FAIL start_ignored: got %b expected 0100", bus.game_state); end
  endtask

  // Player 0 misses; also pins down the 66-cycle move latency.
  task automatic test_miss;
    move_exp_t e;
    bus.player1_board = 64'd1 << 5;
    bus.player2_ships = 64'd1 << 9;
    issue_move;
    cycle(64);
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL decide_state: got %b expected 0101", bus.game_state); end
    checks++; if (bus.active_player !== exp_player) begin errors++; $display("[TB] FAIL decide_player_early: got %b expected %b", bus.active_player, exp_player); end
    cycle(1);
    e = exp_q.pop_front();
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL miss_state: got %b expected 0101", bus.game_state); end
    checks++; if (bus.active_player !== ~e.player) begin errors++; $display("[TB] FAIL miss_player: got %b expected %b", bus.active_player, ~e.player); end
    checks++; if (bus.hits_p1 !== e.hits) begin errors++; $display("[TB] FAIL miss_hits: got %0d expected %0d", bus.hits_p1, e.hits); end
    checks++; if (bus.game_over !== e.win) begin errors++; $display("[TB] FAIL miss_over: got %b expected %b", bus.game_over, e.win); end
    exp_player = ~e.player;
  endtask

  // Entered right after BLANK entry: early ticks dropped, saturated tick taken.
  task automatic test_blank;
    cycle(3);
    pulse_tick;
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL blank_early_tick: got %b expected 0101", bus.game_state); end
    cycle(4);
    pulse_tick;
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL blank_last_early_tick: got %b expected 0101", bus.game_state); end
    pulse_tick;
    checks++; if (bus.game_state !== 4'b0100) begin errors++; $display("[TB] FAIL blank_accept: got %b expected 0100", bus.game_state); end
    checks++; if (bus.active_player !== exp_player) begin errors++; $display("[TB] FAIL blank_player: got %b expected %b", bus.active_player, exp_player); end
  endtask

  task automatic test_player1_move;
    move_exp_t e;
    bus.player1_ships = (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30);
    bus.player2_board = (64'd1 << 10) | (64'd1 << 40);
    issue_move;
    cycle(65);
    e = exp_q.pop_front();
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL p1move_state: got %b expected 0101", bus.game_state); end
    checks++; if (bus.hits_p2 !== e.hits) begin errors++; $display("[TB] FAIL p1move_hits: got %0d expected %0d", bus.hits_p2, e.hits); end
    checks++; if (bus.active_player !== ~e.player) begin errors++; $display("[TB] FAIL p1move_player: got %b expected %b", bus.active_player, ~e.player); end
    exp_player = ~e.player;
    skip_blank;
    checks++; if (bus.game_state !== 4'b0100) begin errors++; $display("[TB] FAIL p1move_back: got %b expected 0100", bus.game_state); end
  endtask

  task automatic test_win_p0;
    move_exp_t e;
    bus.player2_ships = 64'h7;
    bus.player1_board = 64'h87;
    issue_move;
    cycle(65);
    e = exp_q.pop_front();
    checks++; if (bus.game_state !== 4'b0110) begin errors++; $display("[TB] FAIL win0_state: got %b expected 0110", bus.game_state); end
    checks++; if (bus.game_over !== e.win) begin errors++; $display("[TB] FAIL win0_over: got %b expected %b", bus.game_over, e.win); end
    checks++; if (bus.winner !== e.player) begin errors++; $display("[TB] FAIL win0_winner: got %b expected %b", bus.winner, e.player); end
    checks++; if (bus.hits_p1 !== e.hits) begin errors++; $display("[TB] FAIL win0_hits: got %0d expected %0d", bus.hits_p1, e.hits); end
    checks++; if (bus.hits_p2 !== 7'd1) begin errors++; $display("[TB] FAIL win0_hits_p2_held: got %0d expected 1", bus.hits_p2); end
    pulse_tick;
    checks++; if (bus.game_state !== 4'b0110) begin errors++; $display("[TB] FAIL ending_tick: got %b expected 0110", bus.game_state); end
  endtask

  task automatic test_restart;
    pulse_restart;
    exp_player = 1'b0;
    checks++; if (bus.game_state !== 4'b0000) begin errors++; $display("[TB] FAIL restart_state: got %b expected 0000", bus.game_state); end
    checks++; if ({bus.game_active, bus.active_player, bus.game_over, bus.winner} !== 4'b0000) begin errors++; $display("[TB] FAIL restart_flags: got %b expected 0000", {bus.game_active, bus.active_player, bus.game_over, bus.winner}); end
    checks++; if ({bus.hits_p1, bus.hits_p2} !== 14'd0) begin errors++; $display("[TB] FAIL restart_hits: got %0d/%0d expected 0/0", bus.hits_p1, bus.hits_p2); end
  endtask

  task automatic test_empty_fleet;
    move_exp_t e;
    pulse_start;
    bus.player2_ships = '0;
    bus.player1_board = '1;
    issue_move;
    cycle(65);
    e = exp_q.pop_front();
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL empty_state: got %b expected 0101", bus.game_state); end
    checks++; if (bus.game_over !== e.win) begin errors++; $display("[TB] FAIL empty_over: got %b expected %b", bus.game_over, e.win); end
    checks++; if (bus.active_player !== ~e.player) begin errors++; $display("[TB] FAIL empty_player: got %b expected %b", bus.active_player, ~e.player); end
    exp_player = ~e.player;
    skip_blank;
  endtask

  // Player 1 sinks a single ship on the last square (idx 63).
  task automatic test_win_p1;
    move_exp_t e;
    bus.player1_ships = 64'd1 << 63;
    bus.player2_board = (64'd1 << 63) | 64'd1;
    issue_move;
    cycle(65);
    e = exp_q.pop_front();
    checks++; if (bus.game_state !== 4'b0110) begin errors++; $display("[TB] FAIL win1_state: got %b expected 0110", bus.game_state); end
    checks++; if (bus.winner !== e.player) begin errors++; $display("[TB] FAIL win1_winner: got %b expected %b", bus.winner, e.player); end
    checks++; if (bus.hits_p2 !== e.hits) begin errors++; $display("[TB] FAIL win1_hits: got %0d expected %0d", bus.hits_p2, e.hits); end
    pulse_restart;
    exp_player = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    move_exp_t e;
    pulse_start;
    bus.player1_board = '1;
    bus.player2_ships = 64'hFF;
    issue_move;
    cycle(30);
    rst = 1'b1; cycle(1);
    exp_q.delete();
    exp_player = 1'b0;
    checks++; if (bus.game_state !== 4'b0000) begin errors++; $display("[TB] FAIL midscan_state: got %b expected 0000", bus.game_state); end
    checks++; if ({bus.game_active, bus.active_player, bus.game_over, bus.winner, bus.hits_p1, bus.hits_p2} !== 18'd0) begin errors++; $display("[TB] FAIL midscan_outputs: got %h expected 0", {bus.game_active, bus.active_player, bus.game_over, bus.winner, bus.hits_p1, bus.hits_p2}); end
    rst = 1'b0;
    cycle(1);
    pulse_start;
    bus.player2_ships = 64'hF;
    bus.player1_board = 64'h3;
    issue_move;
    cycle(65);
    e = exp_q.pop_front();
    checks++; if (bus.hits_p1 !== e.hits) begin errors++; $display("[TB] FAIL post_reset_hits: got %0d expected %0d", bus.hits_p1, e.hits); end
    checks++; if (bus.game_state !== 4'b0101) begin errors++; $display("[TB] FAIL post_reset_state: got %b expected 0101", bus.game_state); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_miss;
    test_blank;
    test_player1_move;
    test_win_p0;
    test_restart;
    test_empty_fleet;
    test_win_p1;
    test_reset_mid_scan;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
